// File: rtl/wbt_sample_tx.sv
// rtl/wbt_sample_tx.sv - splits 32-bit WSI words into two 16-bit WSI samples through a small input FIFO
module wbt_sample_tx #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter bit          SWAP       = 1'b0
) (
  input  logic        ctl_Clk,
  input  logic        ctl_MReset_n,
  input  logic        enable,
  input  logic [2:0]  in_MCmd,
  input  logic        in_MReqLast,
  input  logic [11:0] in_MBurstLength,
  input  logic [31:0] in_MData,
  output logic        in_SThreadBusy,
  output logic [2:0]  out_MCmd,
  output logic        out_MReqLast,
  output logic [11:0] out_MBurstLength,
  output logic [15:0] out_MData,
  input  logic        out_SThreadBusy,
  output logic [15:0] underrun_count,
  output logic        overflow
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_FIRST, S_SECOND} state_t;
  typedef struct packed {
    logic        last;
    logic [11:0] len;
    logic [31:0] data;
  } word_t;

  word_t         mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  state_t        state_q;
  logic [15:0]   hold_half_q;
  logic          hold_last_q;
  logic          in_msg_q;
  logic          busy_q;
  logic [2:0]    cmd_q;
  logic          last_q;
  logic [11:0]   blen_q;
  logic [15:0]   data_q;
  logic [15:0]   underrun_q;
  logic          overflow_q;

  logic          full, empty, accept, pop, push, starve;
  word_t         head, word_in;
  logic [15:0]   head_first, head_second;

  function automatic logic [11:0] dbl_len(input logic [11:0] len);
    return len[11] ? 12'hFFF : {len[10:0], 1'b0};
  endfunction

  always_comb begin
    full        = (count_q == FULL_CNT);
    empty       = (count_q == '0);
    head        = mem_q[rd_ptr_q];
    word_in     = '{last: in_MReqLast, len: in_MBurstLength, data: in_MData};
    head_first  = SWAP ? head.data[31:16] : head.data[15:0];
    head_second = SWAP ? head.data[15:0]  : head.data[31:16];
    accept      = (state_q != S_IDLE) && !out_SThreadBusy;
    // A pop refills the holding register either from IDLE or back-to-back after the second half.
    pop         = enable && !empty &&
                  ((state_q == S_IDLE) || ((state_q == S_SECOND) && accept));
    push        = (in_MCmd == 3'b001) && (!full || pop);
    starve      = enable && empty && in_msg_q &&
                  ((state_q == S_IDLE) || ((state_q == S_SECOND) && accept));
    count_d     = count_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  always_ff @(posedge ctl_Clk) begin
    if (push) mem_q[wr_ptr_q] <= word_in;
  end

  always_ff @(posedge ctl_Clk or negedge ctl_MReset_n) begin
    if (!ctl_MReset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      busy_q      <= 1'b0;
      state_q     <= S_IDLE;
      hold_half_q <= '0;
      hold_last_q <= 1'b0;
      in_msg_q    <= 1'b0;
      cmd_q       <= 3'b000;
      last_q      <= 1'b0;
      blen_q      <= '0;
      data_q      <= '0;
      underrun_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      busy_q  <= (count_d == FULL_CNT);
      if ((in_MCmd == 3'b001) && full && !pop) overflow_q <= 1'b1;
      if (starve && (underrun_q != 16'hFFFF)) underrun_q <= underrun_q + 16'd1;
      if (pop) in_msg_q <= !head.last;

      if (pop) begin
        state_q     <= S_FIRST;
        hold_half_q <= head_second;
        hold_last_q <= head.last;
        cmd_q       <= 3'b001;
        data_q      <= head_first;
        blen_q      <= dbl_len(head.len);
        last_q      <= 1'b0;
      end else if ((state_q == S_FIRST) && accept) begin
        state_q <= S_SECOND;
        data_q  <= hold_half_q;
        last_q  <= hold_last_q;
      end else if ((state_q == S_SECOND) && accept) begin
        state_q <= S_IDLE;
        cmd_q   <= 3'b000;
        last_q  <= 1'b0;
      end
    end
  end

  assign in_SThreadBusy   = busy_q;
  assign out_MCmd         = cmd_q;
  assign out_MReqLast     = last_q;
  assign out_MBurstLength = blen_q;
  assign out_MData        = data_q;
  assign underrun_count   = underrun_q;
  assign overflow         = overflow_q;
endmodule

// File: tb/tb_wbt_sample_tx.sv
// tb/tb_wbt_sample_tx.sv - directed and randomized checks of wbt_sample_tx against a sample-queue model
module tb_wbt_sample_tx;
  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [2:0]  in_cmd;
  logic        in_last;
  logic [11:0] in_len;
  logic [31:0] in_data;
  logic        out_busy;

  logic        a_sbusy, a_last, a_ovf;
  logic [2:0]  a_cmd;
  logic [11:0] a_bl;
  logic [15:0] a_data, a_under;
  logic        b_sbusy, b_last, b_ovf;
  logic [2:0]  b_cmd;
  logic [11:0] b_bl;
  logic [15:0] b_data, b_under;

  int n_pass  = 0;
  int n_total = 0;
  bit tog     = 1'b0;
  bit mon_en  = 1'b0;

  typedef struct packed {
    logic [2:0]  cmd;
    logic        last;
    logic [11:0] bl;
    logic [15:0] d;
  } samp_t;

  samp_t exp_q[$];

  wbt_sample_tx #(.FIFO_DEPTH(4), .SWAP(1'b0)) dut (
    .ctl_Clk(clk), .ctl_MReset_n(rst_n), .enable(enable),
    .in_MCmd(in_cmd), .in_MReqLast(in_last), .in_MBurstLength(in_len), .in_MData(in_data),
    .in_SThreadBusy(a_sbusy), .out_MCmd(a_cmd), .out_MReqLast(a_last),
    .out_MBurstLength(a_bl), .out_MData(a_data), .out_SThreadBusy(out_busy),
    .underrun_count(a_under), .overflow(a_ovf)
  );

  wbt_sample_tx #(.FIFO_DEPTH(4), .SWAP(1'b1)) dut_s (
    .ctl_Clk(clk), .ctl_MReset_n(rst_n), .enable(enable),
    .in_MCmd(in_cmd), .in_MReqLast(in_last), .in_MBurstLength(in_len), .in_MData(in_data),
    .in_SThreadBusy(b_sbusy), .out_MCmd(b_cmd), .out_MReqLast(b_last),
    .out_MBurstLength(b_bl), .out_MData(b_data), .out_SThreadBusy(out_busy),
    .underrun_count(b_under), .overflow(b_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Each word becomes low half then high half; length doubles, capped at 4095.
  function automatic void add_word(input logic [31:0] d, input logic last, input int len);
    samp_t s;
    int bl;
    bl = (2 * len > 4095) ? 4095 : 2 * len;
    s.cmd = 3'b001; s.last = 1'b0; s.bl = 12'(bl); s.d = d[15:0];
    exp_q.push_back(s);
    s.last = last; s.d = d[31:16];
    exp_q.push_back(s);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (tog) out_busy = ~out_busy;
  endtask

  task automatic send(input logic [31:0] d, input logic last, input logic [11:0] len);
    in_cmd = 3'b001; in_data = d; in_last = last; in_len = len;
    tick();
    in_cmd = 3'b000;
  endtask

  task automatic send_ready(input logic [31:0] d, input logic last, input logic [11:0] len);
    int n = 0;
    while (a_sbusy && n < 50) begin tick(); n++; end
    chk("ready_timeout", n < 50, 1);
    add_word(d, last, int'(len));
    send(d, last, len);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || a_cmd != 3'b000) && n < budget) begin tick(); n++; end
    chk("drain_left", exp_q.size(), 0);
    chk("drain_cmd", a_cmd, 3'b000);
  endtask

  // Output monitor: every accepted sample must be the next one the model predicts,
  // and a sample stalled by backpressure must not change.
  initial begin
    samp_t cur, held;
    bit held_v;
    held_v = 1'b0;
    forever begin
      @(negedge clk);
      cur.cmd = a_cmd; cur.last = a_last; cur.bl = a_bl; cur.d = a_data;
      if (!mon_en) begin
        held_v = 1'b0;
      end else begin
        if (held_v) chk("hold_stable", cur, held);
        held_v = (a_cmd == 3'b001) && out_busy;
        held   = cur;
        if (a_cmd == 3'b001 && !out_busy) begin
          if (exp_q.size() == 0) chk("extra_sample", exp_q.size(), 1);
          else chk("sample", cur, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        rl;
    logic [11:0] rlen;
    logic [2:0]  rc;

    rst_n = 1'b0; enable = 1'b1; in_cmd = 3'b000; in_last = 1'b0;
    in_len = '0; in_data = '0; out_busy = 1'b0;
    tick(); tick();
    chk("rst_cmd", a_cmd, 3'b000);
    chk("rst_data", a_data, 16'h0);
    chk("rst_last", a_last, 1'b0);
    chk("rst_bl", a_bl, 12'h0);
    chk("rst_sbusy", a_sbusy, 1'b0);
    chk("rst_under", a_under, 16'h0);
    chk("rst_ovf", a_ovf, 1'b0);
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Single word, both swap settings, latency of one and two edges.
    add_word(32'hBEEF_1234, 1'b1, 1);
    send(32'hBEEF_1234, 1'b1, 12'd1);
    tick();
    chk("lat1_cmd", a_cmd, 3'b001);
    chk("lat1_data", a_data, 16'h1234);
    chk("lat1_last", a_last, 1'b0);
    chk("lat1_bl", a_bl, 12'd2);
    chk("swap1_data", b_data, 16'hBEEF);
    tick();
    chk("lat2_data", a_data, 16'hBEEF);
    chk("lat2_last", a_last, 1'b1);
    chk("lat2_bl", a_bl, 12'd2);
    chk("swap2_data", b_data, 16'h1234);
    chk("swap2_last", b_last, 1'b1);
    tick();
    chk("after_msg_cmd", a_cmd, 3'b000);

    // Fill the FIFO with the worker held and downstream busy.
    enable = 1'b0; out_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      add_word(32'hA000_0000 + 32'(i), 1'b0, 5);
      send(32'hA000_0000 + 32'(i), 1'b0, 12'd5);
      if (i == 2) chk("sbusy_at3", a_sbusy, 1'b0);
    end
    chk("sbusy_at4", a_sbusy, 1'b1);
    chk("ovf_before", a_ovf, 1'b0);
    send(32'hDEAD_DEAD, 1'b0, 12'd5);
    chk("ovf_set", a_ovf, 1'b1);
    chk("sbusy_after_drop", a_sbusy, 1'b1);
    enable = 1'b1;
    add_word(32'hA000_0005, 1'b1, 5);
    send(32'hA000_0005, 1'b1, 12'd5);
    chk("full_pushpop_sbusy", a_sbusy, 1'b1);
    chk("full_pushpop_cmd", a_cmd, 3'b001);
    tick(); tick(); tick();
    out_busy = 1'b0;
    wait_drain(100);
    chk("ovf_sticky", a_ovf, 1'b1);

    // Eight-word burst with downstream busy toggling each cycle.
    tog = 1'b1;
    for (int i = 0; i < 8; i++)
      send_ready(32'h5A00_0000 + 32'(i * 32'h0001_0001), i == 7, 12'd8);
    wait_drain(200);
    tog = 1'b0; out_busy = 1'b0;
    tick();

    // Starved message: the output runs dry for four cycles before the last word.
    chk("under_before", a_under, 16'd0);
    add_word(32'h1111_2222, 1'b0, 3);
    send(32'h1111_2222, 1'b0, 12'd3);
    add_word(32'h3333_4444, 1'b0, 3);
    send(32'h3333_4444, 1'b0, 12'd3);
    for (int i = 0; i < 6; i++) tick();
    add_word(32'h5555_6666, 1'b1, 3);
    send(32'h5555_6666, 1'b1, 12'd3);
    chk("under_count", a_under, 16'd4);
    wait_drain(100);
    chk("under_final", a_under, 16'd4);

    // Reset while the second half of a non-final word is stalled.
    add_word(32'hCAFE_F00D, 1'b0, 2);
    send(32'hCAFE_F00D, 1'b0, 12'd2);
    tick(); tick();
    out_busy = 1'b1;
    mon_en = 1'b0;
    chk("pre_rst_data", a_data, 16'hCAFE);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_cmd", a_cmd, 3'b000);
    chk("mid_rst_data", a_data, 16'h0);
    chk("mid_rst_last", a_last, 1'b0);
    chk("mid_rst_bl", a_bl, 12'h0);
    chk("mid_rst_sbusy", a_sbusy, 1'b0);
    chk("mid_rst_under", a_under, 16'h0);
    chk("mid_rst_ovf", a_ovf, 1'b0);
    exp_q.delete();
    @(negedge clk);
    #1;
    rst_n = 1'b1; out_busy = 1'b0; mon_en = 1'b1;
    add_word(32'h7777_8888, 1'b1, 1);
    send(32'h7777_8888, 1'b1, 12'd1);
    tick();
    chk("post_rst_first", a_data, 16'h8888);
    wait_drain(50);
    chk("post_rst_under", a_under, 16'h0);

    // Random traffic: random backpressure, enable, non-write commands and lengths.
    for (int i = 0; i < 300; i++) begin
      out_busy = ($urandom_range(0, 2) == 0);
      enable   = ($urandom_range(0, 3) != 0);
      if (!a_sbusy && $urandom_range(0, 2) != 0) begin
        rd   = $urandom;
        rl   = ($urandom_range(0, 3) == 0);
        rlen = ($urandom & 1) ? 12'($urandom_range(1, 40)) : 12'($urandom_range(2000, 4095));
        add_word(rd, rl, int'(rlen));
        in_cmd = 3'b001; in_data = rd; in_last = rl; in_len = rlen;
      end else begin
        rc = 3'($urandom_range(0, 6));
        if (rc != 3'b000) rc = rc + 3'd1;
        in_cmd = rc; in_data = $urandom; in_last = 1'b1; in_len = 12'($urandom);
      end
      tick();
    end
    in_cmd = 3'b000; enable = 1'b1; out_busy = 1'b0;
    wait_drain(500);
    chk("rand_no_ovf", a_ovf, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
